// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing a - b, LSB first,
// one bit per clock. Each bit is formed by two cascaded half-subtractor stages
// with a registered borrow. Handshake is start/busy/done.
//
// Parameters:
//   WIDTH       operand/result width, 1..32
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request, sampled only while idle
//   a, b        minuend / subtrahend, captured on an accepted start
//   busy        high while the serial operation is running
//   done        one-cycle pulse when diff/borrow_out (and ovf) update
//   diff        a - b modulo 2^WIDTH
//   borrow_out  1 iff a < b (unsigned)
//   ovf         signed overflow; exists only when SERIAL_SUB_OVF_EN is defined
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf port and MSB capture.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH=1 still needs a 1-bit counter.
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d, br_next, last;
    logic             accept, finish;
    logic [WIDTH:0]   sr_cat;
    logic [WIDTH-1:0] sr_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             am, bm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        // First stage: sa - sb; second stage: subtract the incoming borrow.
        d          = sa[0] ^ sb[0] ^ br;
        br_next    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        // Shift d into the MSB; the concat keeps WIDTH=1 free of empty slices.
        sr_cat     = {d, sr};
        sr_next    = sr_cat[WIDTH:1];
        last       = (cnt == CW'(WIDTH - 1));
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am         <= 1'b0;
            bm         <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            done <= finish;
            if (accept) begin
                sa  <= a;
                sb  <= b;
                br  <= 1'b0;
                cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                am  <= a[WIDTH-1];
                bm  <= b[WIDTH-1];
`endif
            end else if (busy) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                sr  <= sr_next;
                br  <= br_next;
                cnt <= cnt + 1'b1;
                if (finish) begin
                    diff       <= sr_next;
                    borrow_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf        <= (am ^ bm) & (sr_next[WIDTH-1] ^ am);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, r;
        sx = longint'(x);
        sy = longint'(y);
        if (x[W-1]) sx = sx - (longint'(1) << W);
        if (y[W-1]) sy = sy - (longint'(1) << W);
        r = sx - sy;
        return (r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)));
    endfunction

    // Reference model: an operation accepted while idle completes W edges later.
    int           m_rem = 0;
    int           m_ndone = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0, p_diff = '0;
    logic         m_bo = 1'b0, p_bo = 1'b0;
    logic         m_ovf = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bo   <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_rem  <= W;
                    p_diff <= W'(a - b);
                    p_bo   <= (a < b);
                    p_ovf  <= ref_ovf(a, b);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done  <= 1'b1;
                    m_ndone <= m_ndone + 1;
                    m_diff  <= p_diff;
                    m_bo    <= p_bo;
                    m_ovf   <= p_ovf;
                end
            end
        end
    end

    bit chk_en = 1'b0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("busy", 32'(busy), 32'(m_rem != 0));
            check_val("done", 32'(done), 32'(m_done));
            check_val("diff", 32'(diff), 32'(m_diff));
            check_val("borrow_out", 32'(borrow_out), 32'(m_bo));
`ifdef SERIAL_SUB_OVF_EN
            check_val("ovf", 32'(ovf), 32'(m_ovf));
`endif
            if (done === 1'b1) done_seen++;
        end
    end

    // Starts an operation and waits (bounded) for done; returns edges from the
    // accepting edge to the edge that raised done.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, output int lat);
        int edges;
        start = 1'b1;
        a     = xa;
        b     = xb;
        @(negedge clk);
        edges = 1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        while (done !== 1'b1 && edges < 4 * W) begin
            @(negedge clk);
            edges++;
        end
        lat = edges - 1;
    endtask

    initial begin
        int lat, d0, n0;

        repeat (2) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_diff", 32'(diff), 32'd0);
        check_val("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_op(8'h5A, 8'h3C, lat);
        check_val("t1_latency", 32'(lat), 32'(W));
        check_val("t1_diff", 32'(diff), 32'h1E);
        check_val("t1_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_val("t1_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);

        run_op(8'h00, 8'h01, lat);
        check_val("t2_diff", 32'(diff), 32'hFF);
        check_val("t2_borrow", 32'(borrow_out), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        check_val("t2_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);

        run_op(8'h80, 8'h01, lat);
        check_val("t3_diff", 32'(diff), 32'h7F);
        check_val("t3_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_val("t3_ovf", 32'(ovf), 32'd1);
`endif
        @(negedge clk);

        // A start pulse while busy must be ignored.
        d0    = done_seen;
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * W) @(negedge clk);
        check_val("t4_done_count", 32'(done_seen - d0), 32'd1);
        check_val("t4_diff", 32'(diff), 32'h0F);

        // Asynchronous reset in the middle of a run.
        d0    = done_seen;
        start = 1'b1; a = 8'h33; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_done", 32'(done), 32'd0);
        check_val("t5_diff", 32'(diff), 32'd0);
        check_val("t5_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_val("t5_ovf", 32'(ovf), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        check_val("t5_no_done", 32'(done_seen - d0), 32'd0);
        run_op(8'h44, 8'h05, lat);
        check_val("t5_latency", 32'(lat), 32'(W));
        check_val("t5_diff_after", 32'(diff), 32'h3F);
        @(negedge clk);

        // start held high: back-to-back operations with changing operands.
        d0    = done_seen;
        n0    = m_ndone;
        start = 1'b1;
        for (int i = 0; i < 5 * (W + 1); i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2 * W) @(negedge clk);
        check_val("t6_done_count", 32'(done_seen - d0), 32'(m_ndone - n0));
        check_val("t6_min_ops", 32'(m_ndone - n0 >= 4), 32'd1);

        // Random traffic, including starts while busy.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2 * W) @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
